// File: rtl/rv32_immediate_generator.sv
// RV32I immediate extractor for the decode stage: selects the format from the opcode,
// assembles and sign-extends the immediate, and registers it with a one-cycle valid.
module rv32_immediate_generator (
  input  logic        Clk_i,
  input  logic        Reset_n_i,
  input  logic        Valid_i,
  input  logic [31:0] Instruction_i,
  output logic [31:0] ExtImmediate_o,
  output logic [2:0]  ImmType_o,
  output logic        Valid_o
);

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [2:0] IMM_NONE = 3'd0;
  localparam logic [2:0] IMM_I    = 3'd1;
  localparam logic [2:0] IMM_S    = 3'd2;
  localparam logic [2:0] IMM_B    = 3'd3;
  localparam logic [2:0] IMM_U    = 3'd4;
  localparam logic [2:0] IMM_J    = 3'd5;

  logic [6:0]  opcode;
  logic [2:0]  imm_type;
  logic [31:0] imm_value;

  assign opcode = Instruction_i[6:0];

  // Format selection looks only at the opcode; funct3/funct7 never matter.
  always_comb begin
    imm_type = IMM_NONE;
    case (opcode)
      OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_SYSTEM: imm_type = IMM_I;
      OPC_STORE:                                  imm_type = IMM_S;
      OPC_BRANCH:                                 imm_type = IMM_B;
      OPC_LUI, OPC_AUIPC:                         imm_type = IMM_U;
      OPC_JAL:                                    imm_type = IMM_J;
      default:                                    imm_type = IMM_NONE;
    endcase
  end

  always_comb begin
    imm_value = 32'h0;
    case (imm_type)
      IMM_I: imm_value = {{20{Instruction_i[31]}}, Instruction_i[31:20]};
      IMM_S: imm_value = {{20{Instruction_i[31]}}, Instruction_i[31:25],
                          Instruction_i[11:7]};
      IMM_B: imm_value = {{19{Instruction_i[31]}}, Instruction_i[31], Instruction_i[7],
                          Instruction_i[30:25], Instruction_i[11:8], 1'b0};
      IMM_U: imm_value = {Instruction_i[31:12], 12'h000};
      IMM_J: imm_value = {{11{Instruction_i[31]}}, Instruction_i[31],
                          Instruction_i[19:12], Instruction_i[20],
                          Instruction_i[30:21], 1'b0};
      default: imm_value = 32'h0;
    endcase
  end

  // Valid_i qualifies Instruction_i for one cycle; there is no ready, so every valid
  // word is accepted. Valid_o marks the cycle in which its result is on the outputs.
  always_ff @(posedge Clk_i or negedge Reset_n_i) begin
    if (!Reset_n_i) begin
      ExtImmediate_o <= 32'h0;
      ImmType_o      <= IMM_NONE;
      Valid_o        <= 1'b0;
    end else begin
      Valid_o <= Valid_i;
      if (Valid_i) begin
        ExtImmediate_o <= imm_value;
        ImmType_o      <= imm_type;
      end
    end
  end

endmodule

// File: tb/tb_rv32_immediate_generator.sv
// Directed table-driven bench for rv32_immediate_generator: one vector per cycle,
// results checked one edge later against hand-computed values.
module tb_rv32_immediate_generator;

  localparam int W = 36;

  logic        Clk_i;
  logic        Reset_n_i;
  logic        Valid_i;
  logic [31:0] Instruction_i;
  logic [31:0] ExtImmediate_o;
  logic [2:0]  ImmType_o;
  logic        Valid_o;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];
  logic [31:0]  last_imm;
  logic [2:0]   last_typ;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] imm;
    logic [2:0]  typ;
  } vec_t;

  vec_t vecs[16];

  rv32_immediate_generator dut (
    .Clk_i          (Clk_i),
    .Reset_n_i      (Reset_n_i),
    .Valid_i        (Valid_i),
    .Instruction_i  (Instruction_i),
    .ExtImmediate_o (ExtImmediate_o),
    .ImmType_o      (ImmType_o),
    .Valid_o        (Valid_o)
  );

  // clock / reset
  initial Clk_i = 1'b0;
  always #5 Clk_i = ~Clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic expect_push(input logic v, input logic [31:0] imm, input logic [2:0] typ);
    if (v) begin
      last_imm = imm;
      last_typ = typ;
    end
    exp_q.push_back({v, last_typ, last_imm});
  endtask

  task automatic check_out(input string name);
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty, got imm %08h type %0d", name, ExtImmediate_o, ImmType_o);
    end else begin
      e = exp_q.pop_front();
      check_val({name, ".imm"},   ExtImmediate_o,           e[31:0]);
      check_val({name, ".type"},  {29'h0, ImmType_o},       {29'h0, e[34:32]});
      check_val({name, ".valid"}, {31'h0, Valid_o},         {31'h0, e[35]});
    end
  endtask

  // driver: apply on falling edge, check just after the next rising edge
  task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] imm,
                       input logic [2:0] typ, input string name);
    @(negedge Clk_i);
    Valid_i       = v;
    Instruction_i = instr;
    expect_push(v, imm, typ);
    @(posedge Clk_i);
    #1;
    check_out(name);
  endtask

  task automatic check_zero(input string name);
    check_val({name, ".imm"},   ExtImmediate_o,     32'h0);
    check_val({name, ".type"},  {29'h0, ImmType_o}, 32'h0);
    check_val({name, ".valid"}, {31'h0, Valid_o},   32'h0);
  endtask

  initial begin
    vecs[0]  = '{32'hFFFFFF83, 32'hFFFFFFFF, 3'd1}; // LOAD
    vecs[1]  = '{32'h00000013, 32'h00000000, 3'd1}; // ADDI
    vecs[2]  = '{32'hAAAAAA23, 32'hFFFFFAB4, 3'd2}; // STORE
    vecs[3]  = '{32'hFE000EE3, 32'hFFFFFFFC, 3'd3}; // BRANCH, in[7]=1 -> bit 11 set
    vecs[4]  = '{32'hFFFFFFE7, 32'hFFFFFFFF, 3'd1}; // JALR
    vecs[5]  = '{32'hAAAAAAEF, 32'hFFFAA2AA, 3'd5}; // JAL
    vecs[6]  = '{32'h00000037, 32'h00000000, 3'd4}; // LUI
    vecs[7]  = '{32'hFFFFFF97, 32'hFFFFF000, 3'd4}; // AUIPC
    vecs[8]  = '{32'h00000000, 32'h00000000, 3'd0}; // all zero
    vecs[9]  = '{32'h00000033, 32'h00000000, 3'd0}; // OP
    vecs[10] = '{32'h40515293, 32'h00000405, 3'd1}; // SRAI: shamt field kept verbatim
    vecs[11] = '{32'h00100073, 32'h00000001, 3'd1}; // EBREAK (SYSTEM)
    vecs[12] = '{32'h0000000F, 32'h00000000, 3'd0}; // FENCE has no immediate here
    vecs[13] = '{32'h80000063, 32'hFFFFF000, 3'd3}; // BRANCH, sign only
    vecs[14] = '{32'h7E000FA3, 32'h000007FF, 3'd2}; // STORE, max positive
    vecs[15] = '{32'h800000EF, 32'hFFF00000, 3'd5}; // JAL, sign only

    Reset_n_i     = 1'b0;
    Valid_i       = 1'b1;
    Instruction_i = 32'hFFFFFF83;
    last_imm      = 32'h0;
    last_typ      = 3'd0;
    repeat (2) @(posedge Clk_i);
    #1;
    check_zero("reset_init");

    @(negedge Clk_i);
    Reset_n_i = 1'b1;
    Valid_i   = 1'b0;

    // main table: back-to-back, one vector per cycle
    for (int i = 0; i < 16; i++)
      drive(1'b1, vecs[i].instr, vecs[i].imm, vecs[i].typ, $sformatf("vec%0d", i));

    // hold: invalid input must not disturb the registered result
    drive(1'b1, 32'hFFFFFF97, 32'hFFFFF000, 3'd4, "hold_load");
    drive(1'b0, 32'h7FF00013, 32'h0, 3'd0, "hold1");
    drive(1'b0, 32'h7FF00013, 32'h0, 3'd0, "hold2");

    // throughput: 8 consecutive valid vectors, Valid_o high on each result
    for (int i = 0; i < 8; i++)
      drive(1'b1, vecs[7 - i].instr, vecs[7 - i].imm, vecs[7 - i].typ, $sformatf("thru%0d", i));

    // asynchronous reset between edges
    drive(1'b1, 32'hFFFFFF83, 32'hFFFFFFFF, 3'd1, "pre_reset");
    #2;
    Reset_n_i = 1'b0;
    #1;
    check_zero("reset_async");
    last_imm = 32'h0;
    last_typ = 3'd0;
    @(negedge Clk_i);
    Valid_i       = 1'b1;
    Instruction_i = 32'hAAAAAA23;
    @(posedge Clk_i);
    #1;
    check_zero("reset_held");

    // release: the very next rising edge captures
    @(negedge Clk_i);
    Reset_n_i = 1'b1;
    expect_push(1'b1, 32'hFFFFFAB4, 3'd2);
    @(posedge Clk_i);
    #1;
    check_out("post_reset");
    drive(1'b0, 32'h00000000, 32'h0, 3'd0, "post_reset_idle");

    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
